timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_timer_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: keypad-loaded mm:ss countdown timer (BCD) with run/pause/clear
// control and a door interlock. The countdown moves one second per tick_1hz
// pulse while running; reaching 0000 produces a one-cycle done pulse.
// Optional feature: define TIMER_BEEP_EN to add the beep output, which is held
// high for BEEP_TICKS tick_1hz pulses after the countdown ends.
// All outputs are registered; clr is an asynchronous active-low reset.
module timer_ctrl #(
  parameter int BEEP_TICKS = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        tick_1hz,
  input  logic        door_closed,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        done
`ifdef TIMER_BEEP_EN
  ,
  output logic        beep
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] time_reg, time_next;
  logic        running_reg;
  logic        done_reg, done_next;

  // Qualified control conditions shared by several states.
  logic        key_ok;
  logic        time_nz;
  logic        can_start;

  assign key_ok    = key_valid && (key_digit <= 4'd9);
  assign time_nz   = (time_reg != 16'h0000);
  assign can_start = start && door_closed && time_nz;

  // One-second BCD decrement, built as a borrow chain across the four nibbles.
  // Each nibble wraps 0 -> its limit when borrowed from: 9 for the ones digits
  // and minute tens, 5 for seconds tens. A seconds-tens digit of 6-9 typed in
  // by the user simply counts down normally because only 0 triggers the wrap.
  // The minute-tens borrow-out is never needed: RUN is only entered with a
  // non-zero time and is left as soon as 0000 is reached.
  logic [15:0] time_dec;
  logic [3:0]  borrow;

  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      localparam logic [3:0] LIMIT = (gi == 1) ? 4'd5 : 4'd9;
      logic [3:0] nib;
      assign nib = time_reg[gi*4 +: 4];
      assign time_dec[gi*4 +: 4] = !borrow[gi]    ? nib   :
                                   (nib == 4'd0)  ? LIMIT :
                                                    (nib - 4'd1);
      if (gi < 3) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] && (nib == 4'd0);
      end
    end
  endgenerate

`ifdef TIMER_BEEP_EN
  // Counts tick_1hz pulses seen while sitting in DONE with beep active.
  localparam int CW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
  logic [CW-1:0] beep_cnt_reg, beep_cnt_next;
  logic          beep_reg, beep_next;
`endif

  // Next-state, next-time and pulse decode; defaults hold everything.
  always_comb begin
    state_next = state_reg;
    time_next  = time_reg;
    done_next  = 1'b0;
`ifdef TIMER_BEEP_EN
    beep_cnt_next = beep_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (stop) begin
          time_next = 16'h0000;
        end else if (key_ok) begin
          time_next  = {time_reg[11:0], key_digit};
          state_next = ENTRY;
        end
      end

      ENTRY: begin
        if (stop) begin
          time_next  = 16'h0000;
          state_next = IDLE;
        end else if (can_start) begin
          state_next = RUN;
        end else if (key_ok) begin
          time_next = {time_reg[11:0], key_digit};
        end
      end

      RUN: begin
        if (stop || !door_closed) begin
          state_next = PAUSE;
        end else if (tick_1hz) begin
          time_next = time_dec;
          if (time_dec == 16'h0000) begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
      end

      PAUSE: begin
        if (stop) begin
          time_next  = 16'h0000;
          state_next = IDLE;
        end else if (can_start) begin
          state_next = RUN;
        end
      end

      DONE: begin
`ifdef TIMER_BEEP_EN
        if (stop || key_valid) begin
          state_next    = IDLE;
          beep_cnt_next = '0;
        end else if (tick_1hz) begin
          if (beep_cnt_reg == CW'(BEEP_TICKS - 1)) begin
            state_next    = IDLE;
            beep_cnt_next = '0;
          end else begin
            beep_cnt_next = beep_cnt_reg + 1'b1;
          end
        end
`else
        state_next = IDLE;
`endif
      end

      default: begin
        state_next = IDLE;
        time_next  = 16'h0000;
      end
    endcase
  end

`ifdef TIMER_BEEP_EN
  // Beep follows DONE occupancy, registered so it lines up with the state.
  always_comb begin
    beep_next = (state_next == DONE);
  end
`endif

  // State, time and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg   <= IDLE;
      time_reg    <= 16'h0000;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
`ifdef TIMER_BEEP_EN
      beep_reg     <= 1'b0;
      beep_cnt_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      time_reg    <= time_next;
      running_reg <= (state_next == RUN);
      done_reg    <= done_next;
`ifdef TIMER_BEEP_EN
      beep_reg     <= beep_next;
      beep_cnt_reg <= beep_cnt_next;
`endif
    end
  end

  assign time_bcd = time_reg;
  assign running  = running_reg;
  assign done     = done_reg;
`ifdef TIMER_BEEP_EN
  assign beep     = beep_reg;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed-vector bench for timer_ctrl. Inputs change 1 time
// unit after a rising edge; outputs are sampled at that same point, i.e. one
// edge after the causing input. Works with or without TIMER_BEEP_EN.
module tb_timer_ctrl;

  logic        clk;
  logic        clr;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        start;
  logic        stop;
  logic        tick_1hz;
  logic        door_closed;
  logic [15:0] time_bcd;
  logic        running;
  logic        done;
`ifdef TIMER_BEEP_EN
  logic        beep;
`endif

  int vectors     = 0;
  int miscompares = 0;

  timer_ctrl #(.BEEP_TICKS(3)) dut (
    .clk         (clk),
    .clr         (clr),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop        (stop),
    .tick_1hz    (tick_1hz),
    .door_closed (door_closed),
    .time_bcd    (time_bcd),
    .running     (running),
    .done        (done)
`ifdef TIMER_BEEP_EN
    ,
    .beep        (beep)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: advance one edge, outputs then reflect the inputs.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    cycle();
    key_valid = 1'b0;
    key_digit = 4'd0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cycle();
    tick_1hz = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0;
    stop = 1'b0; tick_1hz = 1'b0; door_closed = 1'b1;
    #2 clr = 1'b0;
    #2;
    vectors++;
    if (time_bcd !== 16'h0000) begin
      miscompares++; $display("FAIL reset_time: got %h expected 0000", time_bcd);
    end
    vectors++;
    if (running !== 1'b0) begin
      miscompares++; $display("FAIL reset_running: got %b expected 0", running);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL reset_done: got %b expected 0", done);
    end
`ifdef TIMER_BEEP_EN
    vectors++;
    if (beep !== 1'b0) begin
      miscompares++; $display("FAIL reset_beep: got %b expected 0", beep);
    end
`endif
    @(negedge clk);
    clr = 1'b1;
    cycle();
  endtask

  task automatic test_entry();
    press(4'd1);
    vectors++;
    if (time_bcd !== 16'h0001) begin
      miscompares++; $display("FAIL entry_1: got %h expected 0001", time_bcd);
    end
    press(4'd3);
    vectors++;
    if (time_bcd !== 16'h0013) begin
      miscompares++; $display("FAIL entry_13: got %h expected 0013", time_bcd);
    end
    press(4'd0);
    vectors++;
    if (time_bcd !== 16'h0130) begin
      miscompares++; $display("FAIL entry_130: got %h expected 0130", time_bcd);
    end
    do_start();
    vectors++;
    if (running !== 1'b1 || time_bcd !== 16'h0130) begin
      miscompares++; $display("FAIL entry_start: got running=%b time=%h expected 1/0130", running, time_bcd);
    end
    tick();
    vectors++;
    if (running !== 1'b1 || time_bcd !== 16'h0129) begin
      miscompares++; $display("FAIL entry_tick: got running=%b time=%h expected 1/0129", running, time_bcd);
    end
    do_stop();
    vectors++;
    if (running !== 1'b0 || time_bcd !== 16'h0129) begin
      miscompares++; $display("FAIL entry_pause: got running=%b time=%h expected 0/0129", running, time_bcd);
    end
    do_stop();
    vectors++;
    if (time_bcd !== 16'h0000) begin
      miscompares++; $display("FAIL entry_clear: got %h expected 0000", time_bcd);
    end
  endtask

  task automatic test_bad_key();
    press(4'd12);
    vectors++;
    if (time_bcd !== 16'h0000) begin
      miscompares++; $display("FAIL badkey_idle: got %h expected 0000", time_bcd);
    end
    do_start();
    vectors++;
    if (running !== 1'b0) begin
      miscompares++; $display("FAIL start_zero: got running=%b expected 0", running);
    end
    press(4'd5);
    press(4'd15);
    vectors++;
    if (time_bcd !== 16'h0005) begin
      miscompares++; $display("FAIL badkey_entry: got %h expected 0005", time_bcd);
    end
    tick();
    vectors++;
    if (time_bcd !== 16'h0005) begin
      miscompares++; $display("FAIL tick_entry: got %h expected 0005", time_bcd);
    end
    do_stop();
    vectors++;
    if (time_bcd !== 16'h0000) begin
      miscompares++; $display("FAIL badkey_clear: got %h expected 0000", time_bcd);
    end
  endtask

  task automatic test_borrow();
    logic [15:0] loads [4];
    logic [15:0] exps  [4];
    logic [15:0] ld;
    loads = '{16'h0100, 16'h1000, 16'h0090, 16'h9999};
    exps  = '{16'h0059, 16'h0959, 16'h0089, 16'h9998};
    for (int i = 0; i < 4; i++) begin
      ld = loads[i];
      press(ld[15:12]);
      press(ld[11:8]);
      press(ld[7:4]);
      press(ld[3:0]);
      vectors++;
      if (time_bcd !== ld) begin
        miscompares++; $display("FAIL borrow_load: got %h expected %h", time_bcd, ld);
      end
      do_start();
      tick();
      vectors++;
      if (time_bcd !== exps[i] || running !== 1'b1) begin
        miscompares++; $display("FAIL borrow_dec: got time=%h running=%b expected %h/1", time_bcd, running, exps[i]);
      end
      do_stop();
      do_stop();
    end
  endtask

  task automatic test_done();
    press(4'd0);
    press(4'd2);
    do_start();
    tick();
    vectors++;
    if (time_bcd !== 16'h0001 || done !== 1'b0 || running !== 1'b1) begin
      miscompares++; $display("FAIL done_pre: got time=%h done=%b running=%b expected 0001/0/1", time_bcd, done, running);
    end
    tick();
    vectors++;
    if (time_bcd !== 16'h0000 || done !== 1'b1 || running !== 1'b0) begin
      miscompares++; $display("FAIL done_pulse: got time=%h done=%b running=%b expected 0000/1/0", time_bcd, done, running);
    end
    cycle();
    vectors++;
    if (done !== 1'b0 || running !== 1'b0) begin
      miscompares++; $display("FAIL done_end: got done=%b running=%b expected 0/0", done, running);
    end
`ifdef TIMER_BEEP_EN
    vectors++;
    if (beep !== 1'b1) begin
      miscompares++; $display("FAIL beep_on: got %b expected 1", beep);
    end
    tick();
    tick();
    vectors++;
    if (beep !== 1'b1) begin
      miscompares++; $display("FAIL beep_hold: got %b expected 1", beep);
    end
    tick();
    vectors++;
    if (beep !== 1'b0) begin
      miscompares++; $display("FAIL beep_off: got %b expected 0", beep);
    end
`endif
    press(4'd7);
    vectors++;
    if (time_bcd !== 16'h0007) begin
      miscompares++; $display("FAIL done_idle_key: got %h expected 0007", time_bcd);
    end
    do_stop();
  endtask

  task automatic test_door();
    press(4'd4);
    press(4'd5);
    do_start();
    door_closed = 1'b0;
    tick_1hz = 1'b1;
    cycle();
    tick_1hz = 1'b0;
    vectors++;
    if (running !== 1'b0 || time_bcd !== 16'h0045) begin
      miscompares++; $display("FAIL door_pause: got running=%b time=%h expected 0/0045", running, time_bcd);
    end
    do_start();
    vectors++;
    if (running !== 1'b0) begin
      miscompares++; $display("FAIL door_open_start: got running=%b expected 0", running);
    end
    tick();
    vectors++;
    if (time_bcd !== 16'h0045) begin
      miscompares++; $display("FAIL tick_pause: got %h expected 0045", time_bcd);
    end
    door_closed = 1'b1;
    do_start();
    vectors++;
    if (running !== 1'b1 || time_bcd !== 16'h0045) begin
      miscompares++; $display("FAIL door_resume: got running=%b time=%h expected 1/0045", running, time_bcd);
    end
    tick();
    vectors++;
    if (time_bcd !== 16'h0044) begin
      miscompares++; $display("FAIL door_tick: got %h expected 0044", time_bcd);
    end
    do_stop();
    do_stop();
  endtask

  task automatic test_stop();
    press(4'd3);
    press(4'd0);
    do_start();
    stop = 1'b1;
    tick_1hz = 1'b1;
    cycle();
    stop = 1'b0;
    tick_1hz = 1'b0;
    vectors++;
    if (running !== 1'b0 || time_bcd !== 16'h0030) begin
      miscompares++; $display("FAIL stop_pause: got running=%b time=%h expected 0/0030", running, time_bcd);
    end
    do_stop();
    vectors++;
    if (time_bcd !== 16'h0000) begin
      miscompares++; $display("FAIL stop_clear: got %h expected 0000", time_bcd);
    end
    press(4'd3);
    press(4'd0);
    start = 1'b1;
    stop = 1'b1;
    cycle();
    start = 1'b0;
    stop = 1'b0;
    vectors++;
    if (running !== 1'b0 || time_bcd !== 16'h0000) begin
      miscompares++; $display("FAIL stop_priority: got running=%b time=%h expected 0/0000", running, time_bcd);
    end
  endtask

  task automatic test_async_reset();
    press(4'd3);
    press(4'd0);
    do_start();
    tick();
    vectors++;
    if (time_bcd !== 16'h0029 || running !== 1'b1) begin
      miscompares++; $display("FAIL areset_pre: got time=%h running=%b expected 0029/1", time_bcd, running);
    end
    #2 clr = 1'b0;
    #1;
    vectors++;
    if (time_bcd !== 16'h0000 || running !== 1'b0) begin
      miscompares++; $display("FAIL areset_now: got time=%h running=%b expected 0000/0", time_bcd, running);
    end
    #2 clr = 1'b1;
    cycle();
    vectors++;
    if (time_bcd !== 16'h0000 || running !== 1'b0) begin
      miscompares++; $display("FAIL areset_after: got time=%h running=%b expected 0000/0", time_bcd, running);
    end
    press(4'd2);
    vectors++;
    if (time_bcd !== 16'h0002) begin
      miscompares++; $display("FAIL areset_key: got %h expected 0002", time_bcd);
    end
    do_stop();
  endtask

  // Directed scenarios in sequence, then the summary.
  initial begin
    test_reset();
    test_entry();
    test_bad_key();
    test_borrow();
    test_done();
    test_door();
    test_stop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
